// File: rtl/quadrature_decoder_if.sv
// Pin/result bundle for one rotary encoder channel pair.
// master: the side driving the raw pins and reading the count.
// slave:  the decoder itself.
interface quadrature_decoder_if;
    logic              enc_a;
    logic              enc_b;
    logic signed [1:0] encoder_value;
    logic              step_up;
    logic              step_down;
    logic              error;

    modport master (
        output enc_a, enc_b,
        input  encoder_value, step_up, step_down, error
    );

    modport slave (
        input  enc_a, enc_b,
        output encoder_value, step_up, step_down, error
    );
endinterface

// File: rtl/quadrature_decoder.sv
// Rotary encoder front end: 2-FF synchroniser, per-channel debounce,
// quadrature state decoder and a 2-bit wrapping signed position count.
// Optional build macro QUADRATURE_DETENT_EN: count only on entry into
// IDLE_STATE (one count per mechanical detent) instead of every
// legal quarter-step.
module quadrature_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter logic [1:0]  IDLE_STATE      = 2'b11
) (
    input  logic                 clk,
    input  logic                 reset,
    quadrature_decoder_if.slave  enc
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Position of an {a,b} pair along the forward Gray cycle 00,01,11,10.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // One debounce step for a single channel; returns {filt_next, cnt_next}.
    function automatic logic [8:0] debounce(input logic s, input logic f,
                                            input logic [7:0] cnt);
        if (s == f)
            return {f, 8'd0};
        else if (cnt == DB_LAST)
            return {s, 8'd0};
        else
            return {f, cnt + 8'd1};
    endfunction

    // Two's complement +/-1 on the 2-bit count; wraps naturally.
    function automatic logic signed [1:0] wrap_step(input logic signed [1:0] v,
                                                    input logic up);
        return up ? v + 2'sd1 : v - 2'sd1;
    endfunction

    logic [1:0]        sync1_q, sync1_d;
    logic [1:0]        sync2_q, sync2_d;
    logic [1:0]        filt_q,  filt_d;
    logic [1:0]        prev_q,  prev_d;
    logic [7:0]        cnt_a_q, cnt_a_d;
    logic [7:0]        cnt_b_q, cnt_b_d;
    logic signed [1:0] value_q, value_d;
    logic              up_q,    up_d;
    logic              down_q,  down_d;
    logic              err_q,   err_d;
    logic [1:0]        delta;
    logic              count_ok;

    // Synchroniser shift and per-channel debounce filters.
    always_comb begin
        sync1_d = {enc.enc_a, enc.enc_b};
        sync2_d = sync1_q;
        {filt_d[1], cnt_a_d} = debounce(sync2_q[1], filt_q[1], cnt_a_q);
        {filt_d[0], cnt_b_d} = debounce(sync2_q[0], filt_q[0], cnt_b_q);
    end

    // Quadrature decode: classify filt vs prev, update count and pulses.
    always_comb begin
        delta   = gray_pos(filt_q) - gray_pos(prev_q);
        prev_d  = filt_q;
        value_d = value_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        err_d   = 1'b0;
`ifdef QUADRATURE_DETENT_EN
        count_ok = (filt_q == IDLE_STATE);
`else
        count_ok = 1'b1;
`endif
        case (delta)
            2'd1: if (count_ok) begin
                value_d = wrap_step(value_q, 1'b1);
                up_d    = 1'b1;
            end
            2'd3: if (count_ok) begin
                value_d = wrap_step(value_q, 1'b0);
                down_d  = 1'b1;
            end
            2'd2:    err_d = 1'b1;
            default: ;
        endcase
    end

    // State registers; async reset returns everything to the pull-up idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= IDLE_STATE;
            sync2_q <= IDLE_STATE;
            filt_q  <= IDLE_STATE;
            prev_q  <= IDLE_STATE;
            cnt_a_q <= 8'd0;
            cnt_b_q <= 8'd0;
            value_q <= 2'sd0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            prev_q  <= prev_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            value_q <= value_d;
            up_q    <= up_d;
            down_q  <= down_d;
            err_q   <= err_d;
        end
    end

    assign enc.encoder_value = value_q;
    assign enc.step_up       = up_q;
    assign enc.step_down     = down_q;
    assign enc.error         = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: directed steps followed by a random
// encoder walk, every cycle compared with a behavioural model.
module tb_quadrature_decoder;

    localparam int         D    = 8;
    localparam logic [1:0] IDLE = 2'b11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    quadrature_decoder_if bus();

    quadrature_decoder #(.DEBOUNCE_CYCLES(D), .IDLE_STATE(IDLE)) dut (
        .clk   (clk),
        .reset (reset),
        .enc   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int up_seen = 0, down_seen = 0, err_seen = 0;

    // Forward rotation order of the {a,b} pins.
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Model state: pins seen two edges ago, accepted channel values,
    // consecutive-disagreement run lengths, last decoded state, count.
    logic [1:0] m_s1, m_s2, m_filt, m_prev;
    int         m_run [2];
    int         m_val;
    bit         m_up, m_down, m_err;

    function automatic int pos_of(logic [1:0] ab);
        for (int i = 0; i < 4; i++)
            if (seq[i] == ab) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_s1 = IDLE; m_s2 = IDLE; m_filt = IDLE; m_prev = IDLE;
        m_run[0] = 0; m_run[1] = 0;
        m_val = 0; m_up = 0; m_down = 0; m_err = 0;
    endtask

    // Predict the effect of the next rising edge with the current pins.
    task automatic model_edge();
        logic [1:0] pins;
        int steps;
        bit counts;
        pins  = {bus.enc_a, bus.enc_b};
        steps = (pos_of(m_filt) - pos_of(m_prev) + 4) % 4;
`ifdef QUADRATURE_DETENT_EN
        counts = (m_filt == IDLE);
`else
        counts = 1'b1;
`endif
        m_up   = (steps == 1) && counts;
        m_down = (steps == 3) && counts;
        m_err  = (steps == 2);
        if (m_up)   m_val = (m_val + 1) % 4;
        if (m_down) m_val = (m_val + 3) % 4;
        m_prev = m_filt;
        for (int ch = 0; ch < 2; ch++) begin
            if (m_s2[ch] == m_filt[ch]) m_run[ch] = 0;
            else begin
                m_run[ch]++;
                if (m_run[ch] == D) begin
                    m_filt[ch] = m_s2[ch];
                    m_run[ch]  = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = pins;
    endtask

    task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs();
        check("encoder_value", {6'b0, bus.encoder_value}, 8'(m_val));
        check("step_up",   {7'b0, bus.step_up},   {7'b0, m_up});
        check("step_down", {7'b0, bus.step_down}, {7'b0, m_down});
        check("error",     {7'b0, bus.error},     {7'b0, m_err});
        if (bus.step_up   === 1'b1) up_seen++;
        if (bus.step_down === 1'b1) down_seen++;
        if (bus.error     === 1'b1) err_seen++;
    endtask

    // Starts and ends on a falling edge; pins are changed only there.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic hold(int n);
        repeat (n) cycle();
    endtask

    task automatic set_pins(logic [1:0] ab);
        bus.enc_a = ab[1];
        bus.enc_b = ab[0];
    endtask

    task automatic apply_reset(int n);
        reset = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        repeat (n) begin
            @(negedge clk);
            compare_outputs();
        end
        reset = 1'b1;
    endtask

    initial begin
        int lat, u0, d0, e0, pi, w, act;
        logic [1:0] v0, ab;

        // Power-up reset with idle pins.
        set_pins(IDLE);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset(2);

        // Idle for 100 cycles: nothing moves.
        hold(100);
        check("idle_value", {6'b0, bus.encoder_value}, 8'd0);
        check("idle_pulses", 8'(up_seen + down_seen + err_seen), 8'd0);

        // One full forward cycle from idle, first step timed.
        u0 = up_seen;
        lat = 0;
        set_pins(2'b10);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (bus.step_up === 1'b1 && lat == 0) lat = k;
        end
        set_pins(2'b00); hold(20);
        set_pins(2'b01); hold(20);
        set_pins(2'b11); hold(20);
`ifdef QUADRATURE_DETENT_EN
        check("fwd_ups",   8'(up_seen - u0), 8'd1);
        check("fwd_value", {6'b0, bus.encoder_value}, 8'd1);
`else
        check("fwd_latency", 8'(lat), 8'(D + 3));
        check("fwd_ups",   8'(up_seen - u0), 8'd4);
        check("fwd_value", {6'b0, bus.encoder_value}, 8'd0);
`endif

        // One full reverse cycle back to idle.
        d0 = down_seen;
        set_pins(2'b01); hold(20);
        set_pins(2'b00); hold(20);
        set_pins(2'b10); hold(20);
        set_pins(2'b11); hold(20);
`ifdef QUADRATURE_DETENT_EN
        check("rev_downs", 8'(down_seen - d0), 8'd1);
`else
        check("rev_downs", 8'(down_seen - d0), 8'd4);
`endif
        check("rev_value", {6'b0, bus.encoder_value}, 8'd0);

`ifndef QUADRATURE_DETENT_EN
        // Short glitches on A are rejected; a D-cycle pulse is accepted.
        foreach (seq[i]) begin end
        for (int g = 0; g < 3; g++) begin
            w  = (g == 0) ? 5 : (g == 1) ? 7 : 8;
            u0 = up_seen; d0 = down_seen;
            set_pins(2'b01); hold(w);
            set_pins(2'b11); hold(20);
            check("glitch_ups",   8'(up_seen - u0),   (w == D) ? 8'd1 : 8'd0);
            check("glitch_downs", 8'(down_seen - d0), (w == D) ? 8'd1 : 8'd0);
            check("glitch_value", {6'b0, bus.encoder_value}, 8'd0);
        end

        // Both pins at once is illegal; a following legal step counts.
        e0 = err_seen;
        v0 = bus.encoder_value;
        set_pins(2'b00); hold(20);
        check("illegal_err",   8'(err_seen - e0), 8'd1);
        check("illegal_value", {6'b0, bus.encoder_value}, {6'b0, v0});
        set_pins(2'b01); hold(20);
        check("post_illegal_value", {6'b0, bus.encoder_value}, {6'b0, v0 + 2'b01});
        set_pins(2'b11); hold(20);
`endif

        // Reset in the middle of a debounce window discards it.
        apply_reset(2);
        hold(5);
        u0 = up_seen; d0 = down_seen; e0 = err_seen;
        set_pins(2'b01); hold(4);
        set_pins(2'b11);
        apply_reset(4);
        hold(30);
        check("midreset_value", {6'b0, bus.encoder_value}, 8'd0);
        check("midreset_pulses", 8'((up_seen - u0) + (down_seen - d0) + (err_seen - e0)), 8'd0);

        // Random walk: steps, glitches and illegal jumps with random holds.
        pi = 2;
        for (int it = 0; it < 90; it++) begin
            act = $urandom_range(0, 9);
            if (act < 4)      pi = (pi + 1) % 4;
            else if (act < 8) pi = (pi + 3) % 4;
            else if (act == 9) pi = (pi + 2) % 4;
            if (act == 8) begin
                ab = seq[pi] ^ ($urandom_range(0, 1) ? 2'b10 : 2'b01);
                set_pins(ab);
                hold($urandom_range(1, D + 2));
            end
            set_pins(seq[pi]);
            hold($urandom_range(1, 24));
        end
        hold(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
